// File: rtl/lfsr_checker.sv
// lfsr_checker - receive-side PRBS checker for the XNOR Fibonacci LFSR stream.
//
// Loads received bits into a local LFSR until NUM_BITS bits are in and
// LOCK_MATCHES consecutive predictions are correct, then declares lock. While
// locked the local LFSR runs free, each mispredicted bit is flagged and counted,
// and LOSS_ERRS errors within one WINDOW-beat window drop lock.
//
// Ports:
//   clk         clock, all registers update on its rising edge
//   reset       synchronous active-high reset
//   enable      checker enable; beats ignored when low
//   bit_valid   bit_in carries a stream bit this cycle
//   bit_in      received stream bit
//   clear_count clears err_count
//   lock        checker synchronised
//   bit_err     one-cycle pulse per mismatched bit while locked
//   err_count   saturating count of errors while locked (ERR_W bits)
//   lfsr_state  local LFSR register (NUM_BITS bits)
//   lockup      (LFSR_LOCKUP_DET_EN only) local LFSR holds all ones
//
// Build option: define LFSR_LOCKUP_DET_EN to treat the all-ones XNOR lockup
// state as invalid (no lock in SEARCH, forced back to SEARCH when locked).
module lfsr_checker #(
   parameter int unsigned NUM_BITS     = 5,
   parameter int unsigned LOCK_MATCHES = 8,
   parameter int unsigned WINDOW       = 32,
   parameter int unsigned LOSS_ERRS    = 4,
   parameter int unsigned ERR_W        = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                bit_valid,
   input  logic                bit_in,
   input  logic                clear_count,
   output logic                lock,
   output logic                bit_err,
   output logic [ERR_W-1:0]    err_count,
`ifdef LFSR_LOCKUP_DET_EN
   output logic                lockup,
`endif
   output logic [NUM_BITS-1:0] lfsr_state
);

   function automatic logic [31:0] tp(input int unsigned k);
      return 32'd1 << (k - 1);
   endfunction

   function automatic logic [31:0] tap_mask(input int unsigned n);
      logic [31:0] m;
      m = '0;
      case (n)
         3:  m = tp(3)  | tp(2);
         4:  m = tp(4)  | tp(3);
         5:  m = tp(5)  | tp(3);
         6:  m = tp(6)  | tp(5);
         7:  m = tp(7)  | tp(6);
         8:  m = tp(8)  | tp(6)  | tp(5)  | tp(4);
         9:  m = tp(9)  | tp(5);
         10: m = tp(10) | tp(7);
         11: m = tp(11) | tp(9);
         12: m = tp(12) | tp(6)  | tp(4)  | tp(1);
         13: m = tp(13) | tp(4)  | tp(3)  | tp(1);
         14: m = tp(14) | tp(5)  | tp(3)  | tp(1);
         15: m = tp(15) | tp(14);
         16: m = tp(16) | tp(15) | tp(13) | tp(4);
         17: m = tp(17) | tp(14);
         18: m = tp(18) | tp(11);
         19: m = tp(19) | tp(6)  | tp(2)  | tp(1);
         20: m = tp(20) | tp(17);
         21: m = tp(21) | tp(19);
         22: m = tp(22) | tp(21);
         23: m = tp(23) | tp(18);
         24: m = tp(24) | tp(23) | tp(22) | tp(17);
         25: m = tp(25) | tp(22);
         26: m = tp(26) | tp(6)  | tp(2)  | tp(1);
         27: m = tp(27) | tp(5)  | tp(2)  | tp(1);
         28: m = tp(28) | tp(25);
         29: m = tp(29) | tp(27);
         30: m = tp(30) | tp(6)  | tp(4)  | tp(1);
         31: m = tp(31) | tp(28);
         32: m = tp(32) | tp(22) | tp(2)  | tp(1);
         default: m = '0;
      endcase
      return m;
   endfunction

   localparam logic [31:0]          TAPS32 = tap_mask(NUM_BITS);
   localparam logic [NUM_BITS-1:0]  TAPS   = TAPS32[NUM_BITS-1:0];

   localparam int unsigned FW = $clog2(NUM_BITS + 1);
   localparam int unsigned MW = $clog2(LOCK_MATCHES + 1);
   localparam int unsigned WW = $clog2(WINDOW + 1);
   localparam int unsigned EW = $clog2(LOSS_ERRS + 1);

   localparam logic [FW-1:0] FILL_MAX    = FW'(NUM_BITS);
   localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_MATCHES - 1);
   localparam logic [WW-1:0] WINDOW_LAST = WW'(WINDOW - 1);
   localparam logic [EW-1:0] LOSS_LAST   = EW'(LOSS_ERRS - 1);

   typedef enum logic {S_SEARCH, S_LOCKED} state_t;

   state_t              r_state;
   logic [NUM_BITS-1:0] r_sr;
   logic [FW-1:0]       r_fill_cnt;
   logic [MW-1:0]       r_match_cnt;
   logic [WW-1:0]       r_win_cnt;
   logic [EW-1:0]       r_win_err;
   logic                r_lock;
   logic                r_bit_err;
   logic [ERR_W-1:0]    r_err_count;

   logic                w_beat;
   logic                w_pred;
   logic                w_mismatch;
   logic                w_full;
   logic                w_sr_lockup;
   logic                w_count_err;
   logic [NUM_BITS-1:0] w_sr_next;
   logic [ERR_W-1:0]    w_err_count_next;

   // Both tap sets have an even tap count, so the XNOR chain reduces to
   // inverted parity of the tapped bits.
   assign w_beat     = enable & bit_valid;
   assign w_pred     = ~^(r_sr & TAPS);
   assign w_mismatch = bit_in ^ w_pred;
   assign w_full     = (r_fill_cnt == FILL_MAX);

`ifdef LFSR_LOCKUP_DET_EN
   logic r_lockup;
   assign w_sr_lockup = &r_sr;
   assign lockup      = r_lockup;
`else
   assign w_sr_lockup = 1'b0;
`endif

   always_comb begin
      w_sr_next = {r_sr[NUM_BITS-2:0], (r_state == S_LOCKED) ? w_pred : bit_in};
   end

   // A clear in the same cycle as a counted error leaves that error counted.
   always_comb begin
      w_count_err      = w_beat & (r_state == S_LOCKED) & w_mismatch;
      w_err_count_next = r_err_count;
      if (clear_count)
         w_err_count_next = ERR_W'(w_count_err);
      else if (w_count_err && !(&r_err_count))
         w_err_count_next = r_err_count + ERR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_SEARCH;
         r_sr        <= '0;
         r_fill_cnt  <= '0;
         r_match_cnt <= '0;
         r_win_cnt   <= '0;
         r_win_err   <= '0;
         r_lock      <= 1'b0;
         r_bit_err   <= 1'b0;
         r_err_count <= '0;
`ifdef LFSR_LOCKUP_DET_EN
         r_lockup    <= 1'b0;
`endif
      end else begin
         r_bit_err   <= 1'b0;
         r_err_count <= w_err_count_next;
         if (w_beat) begin
            r_sr <= w_sr_next;
`ifdef LFSR_LOCKUP_DET_EN
            r_lockup <= &w_sr_next;
`endif
            case (r_state)
               S_SEARCH: begin
                  if (!w_full)
                     r_fill_cnt <= r_fill_cnt + FW'(1);
                  if (w_full) begin
                     if (w_sr_lockup || w_mismatch) begin
                        r_match_cnt <= '0;
                     end else if (r_match_cnt == MATCH_LAST) begin
                        r_state     <= S_LOCKED;
                        r_lock      <= 1'b1;
                        r_match_cnt <= '0;
                        r_win_cnt   <= '0;
                        r_win_err   <= '0;
                     end else begin
                        r_match_cnt <= r_match_cnt + MW'(1);
                     end
                  end
               end
               S_LOCKED: begin
                  r_bit_err <= w_mismatch;
                  // Loss of lock outranks the end-of-window clear.
                  if ((w_mismatch && r_win_err == LOSS_LAST) || w_sr_lockup) begin
                     r_state     <= S_SEARCH;
                     r_lock      <= 1'b0;
                     r_fill_cnt  <= '0;
                     r_match_cnt <= '0;
                     r_win_cnt   <= '0;
                     r_win_err   <= '0;
                  end else if (r_win_cnt == WINDOW_LAST) begin
                     r_win_cnt <= '0;
                     r_win_err <= '0;
                  end else begin
                     r_win_cnt <= r_win_cnt + WW'(1);
                     if (w_mismatch)
                        r_win_err <= r_win_err + EW'(1);
                  end
               end
               default: r_state <= S_SEARCH;
            endcase
         end
      end
   end

   assign lock       = r_lock;
   assign bit_err    = r_bit_err;
   assign err_count  = r_err_count;
   assign lfsr_state = r_sr;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker - directed bench for lfsr_checker. Two instances share one
// stimulus stream: dut0 with default parameters, dut1 with a 4-bit error
// counter. A 5-bit XNOR generator (taps 5,3, seed 0) produces the stream;
// a per-cycle vector table sets controls, injected bit errors and the
// expected lock / bit_err / err_count after each cycle.
module tb_lfsr_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       bit_valid = 1'b0;
   logic       bit_in = 1'b0;
   logic       clear_count = 1'b0;
   logic       lock0, bit_err0, lock1, bit_err1;
   logic [15:0] err_count0;
   logic [3:0]  err_count1;
   logic [4:0]  lfsr0, lfsr1;
`ifdef LFSR_LOCKUP_DET_EN
   logic       lockup0, lockup1;
`endif

   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;
   logic [4:0]  g = '0;

   always #5 clk = ~clk;

   lfsr_checker dut0 (
      .clk(clk), .reset(reset), .enable(enable), .bit_valid(bit_valid),
      .bit_in(bit_in), .clear_count(clear_count), .lock(lock0),
      .bit_err(bit_err0), .err_count(err_count0),
`ifdef LFSR_LOCKUP_DET_EN
      .lockup(lockup0),
`endif
      .lfsr_state(lfsr0));

   lfsr_checker #(.ERR_W(4)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .bit_valid(bit_valid),
      .bit_in(bit_in), .clear_count(clear_count), .lock(lock1),
      .bit_err(bit_err1), .err_count(err_count1),
`ifdef LFSR_LOCKUP_DET_EN
      .lockup(lockup1),
`endif
      .lfsr_state(lfsr1));

   typedef struct {
      bit          en;
      bit          vld;
      bit          flip;
      bit          clr;
      bit          e_lock;
      bit          e_err;
      int unsigned e_cnt;
   } vec_t;

   vec_t vt[$];

   task automatic add(input bit en, input bit vld, input bit flip, input bit clr,
                      input bit e_lock, input bit e_err, input int unsigned e_cnt);
      vec_t v;
      v.en = en; v.vld = vld; v.flip = flip; v.clr = clr;
      v.e_lock = e_lock; v.e_err = e_err; v.e_cnt = e_cnt;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // One cycle: drive at negedge, generator advances only on beats,
   // outputs sampled 1 time unit after the rising edge.
   task automatic step(input bit en, input bit vld, input bit flip, input bit clr);
      logic fb;
      @(negedge clk);
      enable = en; bit_valid = vld; clear_count = clr;
      if (en && vld) begin
         fb = ~(g[4] ^ g[2]);
         bit_in = fb ^ flip;
         g = {g[3:0], fb};
      end else begin
         bit_in = flip;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; enable = 1'b0; bit_valid = 1'b0; clear_count = 1'b0; bit_in = 1'b0;
      g = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int unsigned cnt;
      // initial lock: 5 fill beats + 8 matches
      for (int i = 1; i <= 13; i++) add(1, 1, 0, 0, i == 13, 0, 0);
      for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 1, 0, 0);
      // single error while locked
      add(1, 1, 1, 0, 1, 1, 1);
      add(1, 1, 0, 0, 1, 0, 1);
      // idle cycles: bit_valid low, then enable low, with garbage on bit_in
      for (int i = 0; i < 10; i++) add(1, 0, 1, 0, 1, 0, 1);
      for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 1, 0, 1);
      add(1, 1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 39; i++) add(1, 1, 0, 0, 1, 0, 0);
      // 4 errors in 7 beats inside one window: lock drops on the 4th
      add(1, 1, 1, 0, 1, 1, 1);
      add(1, 1, 0, 0, 1, 0, 1);
      add(1, 1, 1, 0, 1, 1, 2);
      add(1, 1, 0, 0, 1, 0, 2);
      add(1, 1, 1, 0, 1, 1, 3);
      add(1, 1, 0, 0, 1, 0, 3);
      add(1, 1, 1, 0, 0, 1, 4);
      // relock after 13 clean beats, count retained
      for (int i = 1; i <= 13; i++) add(1, 1, 0, 0, i == 13, 0, 4);
      // 20 isolated errors, two per window at most
      cnt = 4;
      for (int e = 0; e < 20; e++) begin
         cnt++;
         add(1, 1, 1, 0, 1, 1, cnt);
         for (int i = 0; i < 15; i++) add(1, 1, 0, 0, 1, 0, cnt);
      end
      // clear together with an error leaves one error counted
      add(1, 1, 1, 1, 1, 1, 1);
      add(1, 1, 0, 0, 1, 0, 1);

      // reset state
      do_reset();
      chk("rst_lock", 32'(lock0), 32'd0);
      chk("rst_bit_err", 32'(bit_err0), 32'd0);
      chk("rst_err_count", 32'(err_count0), 32'd0);
      chk("rst_lfsr", 32'(lfsr0), 32'd0);

      foreach (vt[i]) begin
         step(vt[i].en, vt[i].vld, vt[i].flip, vt[i].clr);
         chk($sformatf("v%0d_lock", i), 32'(lock0), 32'(vt[i].e_lock));
         chk($sformatf("v%0d_bit_err", i), 32'(bit_err0), 32'(vt[i].e_err));
         chk($sformatf("v%0d_err_count", i), 32'(err_count0), vt[i].e_cnt);
         chk($sformatf("v%0d_err_count_w4", i), 32'(err_count1),
             (vt[i].e_cnt > 15) ? 32'd15 : vt[i].e_cnt);
         if (vt[i].e_lock) chk($sformatf("v%0d_lfsr", i), 32'(lfsr0), 32'(g));
      end

      // reset while locked
      chk("pre_reset_lock", 32'(lock1), 32'd1);
      do_reset();
      chk("reset_locked_lock", 32'(lock0), 32'd0);
      chk("reset_locked_err_count", 32'(err_count0), 32'd0);
      chk("reset_locked_lfsr", 32'(lfsr0), 32'd0);
      chk("reset_locked_err_count_w4", 32'(err_count1), 32'd0);

      // all-ones stream
`ifdef LFSR_LOCKUP_DET_EN
      chk("lockup_reset", 32'(lockup0), 32'd0);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         enable = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("ones%0d_lock", i), 32'(lock0), 32'd0);
      end
      chk("ones_lockup", 32'(lockup0), 32'd1);
`else
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         enable = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("ones%0d_lock", i), 32'(lock0), 32'(i == 13));
      end
      chk("ones_lfsr", 32'(lfsr0), 32'h1f);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
